// File: rtl/cse_x25_axilite_pkg.sv
// cse_x25_axilite_pkg: AXI-Lite response codes and manager FSM states shared by manager and subordinate
package cse_x25_axilite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RSP
    } state_e;

endpackage

// File: rtl/cse_x25_axilite_manager.sv
// cse_x25_axilite_manager: single-outstanding AXI-Lite initiator driven by a valid/ready command port
module cse_x25_axilite_manager
    import cse_x25_axilite_pkg::*;
#(
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_write_i,
    input  logic [axi_addr_width_p-1:0] cmd_addr_i,
    input  logic [axi_data_width_p-1:0] cmd_data_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic                        rsp_write_o,
    output logic [axi_data_width_p-1:0] rsp_data_o,
    output logic [1:0]                  rsp_resp_o,
    output logic [axi_addr_width_p-1:0] axi_awaddr_o,
    output logic                        axi_awvalid_o,
    input  logic                        axi_awready_i,
    output logic [axi_data_width_p-1:0] axi_wdata_o,
    output logic                        axi_wlast_o,
    output logic                        axi_wvalid_o,
    input  logic                        axi_wready_i,
    input  logic [1:0]                  axi_bresp_i,
    input  logic                        axi_bvalid_i,
    output logic                        axi_bready_o,
    output logic [axi_addr_width_p-1:0] axi_araddr_o,
    output logic                        axi_arvalid_o,
    input  logic                        axi_arready_i,
    input  logic [axi_data_width_p-1:0] axi_rdata_i,
    input  logic [1:0]                  axi_rresp_i,
    input  logic                        axi_rlast_i,
    input  logic                        axi_rvalid_i,
    output logic                        axi_rready_o
);

    state_e                      state_q, state_d;
    logic [axi_addr_width_p-1:0] addr_q;
    logic [axi_data_width_p-1:0] data_q;
    logic                        awvalid_q, wvalid_q, arvalid_q;
    logic                        rsp_valid_q, rsp_write_q;
    logic [axi_data_width_p-1:0] rsp_data_q;
    logic [1:0]                  rsp_resp_q;
    logic                        unused_rlast;

    // single-beat reads make rlast redundant
    assign unused_rlast = axi_rlast_i;

    assign cmd_ready_o   = state_q == IDLE;
    assign axi_bready_o  = state_q == WB;
    assign axi_rready_o  = state_q == RD;
    assign axi_awaddr_o  = addr_q;
    assign axi_araddr_o  = addr_q;
    assign axi_wdata_o   = data_q;
    assign axi_awvalid_o = awvalid_q;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wlast_o   = wvalid_q;
    assign axi_arvalid_o = arvalid_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_write_o   = rsp_write_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_resp_o    = rsp_resp_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid_i ? (cmd_write_i ? WR : RA) : IDLE;
            // AW and W complete independently; leave once neither is still pending
            WR:      state_d = ((!awvalid_q || axi_awready_i) && (!wvalid_q || axi_wready_i)) ? WB : WR;
            WB:      state_d = axi_bvalid_i ? RSP : WB;
            RA:      state_d = axi_arready_i ? RD : RA;
            RD:      state_d = axi_rvalid_i ? RSP : RD;
            RSP:     state_d = rsp_ready_i ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid_i) begin
                addr_q    <= cmd_addr_i;
                data_q    <= cmd_data_i;
                awvalid_q <= cmd_write_i;
                wvalid_q  <= cmd_write_i;
                arvalid_q <= !cmd_write_i;
            end
            if (awvalid_q && axi_awready_i) awvalid_q <= 1'b0;
            if (wvalid_q && axi_wready_i) wvalid_q <= 1'b0;
            if (arvalid_q && axi_arready_i) arvalid_q <= 1'b0;
            if (state_q == WB && axi_bvalid_i) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_resp_q  <= axi_bresp_i;
            end
            if (state_q == RD && axi_rvalid_i) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= 1'b0;
                rsp_data_q  <= axi_rdata_i;
                rsp_resp_q  <= axi_rresp_i;
            end
            if (rsp_valid_q && rsp_ready_i) rsp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cse_x25_axilite_manager.sv
// tb_cse_x25_axilite_manager: scripted AXI-Lite subordinate plus response scoreboard for the manager
module tb_cse_x25_axilite_manager;
    import cse_x25_axilite_pkg::*;

    typedef struct {
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic        cmd_ready_o;
    logic        rsp_valid_o, rsp_write_o;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_resp_o;
    logic [31:0] axi_awaddr_o, axi_wdata_o, axi_araddr_o;
    logic        axi_awvalid_o, axi_wlast_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = OKAY, rresp = OKAY;
    logic [31:0] rdata = '0;

    int          errors = 0, checks = 0;
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    int          awc = 0, wc = 0, arc = 0, b_count = 0;
    logic [1:0]  bresp_cfg = OKAY;
    logic        got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
    logic [31:0] wa, wd, rd;
    logic [31:0] mem [0:63];
    logic [31:0] exp_mem [0:63];
    exp_t        sb [$];

    always #5 clk = ~clk;

    cse_x25_axilite_manager dut (
        .clk_i(clk), .reset_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write_o),
        .rsp_data_o(rsp_data_o), .rsp_resp_o(rsp_resp_o),
        .axi_awaddr_o(axi_awaddr_o), .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(awready),
        .axi_wdata_o(axi_wdata_o), .axi_wlast_o(axi_wlast_o), .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(wready),
        .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(axi_bready_o),
        .axi_araddr_o(axi_araddr_o), .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(arready),
        .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(1'b1), .axi_rvalid_i(rvalid),
        .axi_rready_o(axi_rready_o)
    );

    // subordinate: handshakes observed on the rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        end else begin
            if (bvalid && axi_bready_o) b_pend = 0;
            if (rvalid && axi_rready_o) r_pend = 0;
            if (axi_awvalid_o && awready) begin got_aw = 1; wa = axi_awaddr_o; end
            if (axi_wvalid_o && wready) begin got_w = 1; wd = axi_wdata_o; end
            if (got_aw && got_w) begin
                mem[wa[7:2]] = wd;
                got_aw = 0; got_w = 0; b_pend = 1; b_count++;
            end
            if (axi_arvalid_o && arready) begin r_pend = 1; rd = mem[axi_araddr_o[7:2]]; end
        end
    end

    // subordinate: readies and responses driven on the falling edge
    always @(negedge clk) begin
        awready = axi_awvalid_o && awc >= aw_dly;
        awc = axi_awvalid_o ? awc + 1 : 0;
        wready = axi_wvalid_o && wc >= w_dly;
        wc = axi_wvalid_o ? wc + 1 : 0;
        arready = axi_arvalid_o && arc >= ar_dly;
        arc = axi_arvalid_o ? arc + 1 : 0;
        bvalid = b_pend;
        bresp = bresp_cfg;
        rvalid = r_pend;
        rdata = rd;
        rresp = OKAY;
    end

    // response scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got write=%0b data=%h resp=%0d, required no response", rsp_write_o, rsp_data_o, rsp_resp_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks += 2;
                if (rsp_write_o !== e.w) begin errors++; $display("FAIL rsp_write: got %0b required %0b", rsp_write_o, e.w); end
                if (rsp_data_o !== e.d) begin errors++; $display("FAIL rsp_data: got %h required %h", rsp_data_o, e.d); end
                if (rsp_resp_o !== e.r) begin errors++; $display("FAIL rsp_resp: got %0d required %0d", rsp_resp_o, e.r); end
            end
        end
    end

    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_data = d;
        e.w = w;
        e.d = w ? 32'h0 : exp_mem[a[7:2]];
        e.r = w ? bresp_cfg : OKAY;
        if (w) exp_mem[a[7:2]] = d;
        sb.push_back(e);
        @(negedge clk);
        while (!cmd_ready_o && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL cmd_accept: ready stayed %0b, required 1 within 200 cycles", cmd_ready_o); end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready_o) && n < 500) begin n++; @(negedge clk); end
        checks++;
        if (n >= 500) begin errors++; $display("FAIL drain_timeout: pending=%0d, required 0", sb.size()); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready_o); end
        if ({axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_bready_o, axi_rready_o, rsp_valid_o} !== 6'b0) begin
            errors++; $display("FAIL reset_valids: got %b required 000000",
                {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_bready_o, axi_rready_o, rsp_valid_o});
        end
        if ({axi_awaddr_o, axi_araddr_o, axi_wdata_o} !== 96'h0) begin errors++; $display("FAIL reset_payload: got %h required 0", {axi_awaddr_o, axi_araddr_o, axi_wdata_o}); end
        if ({rsp_data_o, rsp_resp_o, rsp_write_o} !== 35'h0) begin errors++; $display("FAIL reset_rsp: got %h required 0", {rsp_data_o, rsp_resp_o, rsp_write_o}); end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_write_read();
        int lat;
        do_cmd(1, 32'h10, 32'hDEAD_BEEF);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid_o && lat < 50);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL write_latency: got %0d required 3", lat); end
        wait_drain();
        do_cmd(0, 32'h10, 32'h0);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid_o && lat < 50);
        checks += 2;
        if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d required 3", lat); end
        if (rsp_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_deadbeef: got %h required deadbeef", rsp_data_o); end
        wait_drain();
    endtask

    task automatic test_w_before_aw();
        int b0 = b_count, n = 0, wl_bad = 0;
        logic saw = 0;
        aw_dly = 3;
        do_cmd(1, 32'h20, 32'h1234_5678);
        while (!rsp_valid_o && n < 50) begin
            @(negedge clk); n++;
            if (axi_wlast_o !== axi_wvalid_o) wl_bad++;
            if (!axi_wvalid_o && axi_awvalid_o) saw = 1;
        end
        wait_drain();
        aw_dly = 0;
        checks += 3;
        if (saw !== 1'b1) begin errors++; $display("FAIL w_first_split: got %0b required 1 (awvalid held after W)", saw); end
        if (wl_bad != 0) begin errors++; $display("FAIL wlast_tracks_wvalid: got %0d bad cycles required 0", wl_bad); end
        if (b_count - b0 != 1) begin errors++; $display("FAIL single_b: got %0d required 1", b_count - b0); end
        do_cmd(0, 32'h20, 32'h0);
        wait_drain();
    endtask

    task automatic test_rsp_hold();
        logic [31:0] d;
        logic [1:0]  r;
        int n = 0, bad = 0;
        rsp_ready = 0;
        do_cmd(0, 32'h10, 32'h0);
        while (!rsp_valid_o && n < 50) begin @(negedge clk); n++; end
        d = rsp_data_o;
        r = rsp_resp_o;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_data = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== d || rsp_resp_o !== r || cmd_ready_o !== 1'b0) bad++;
        end
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL rsp_hold: got %0d unstable cycles required 0", bad); end
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rsp_hold_data: got %h required deadbeef", d); end
        @(posedge clk); #1 rsp_ready = 1;
        do_cmd(1, 32'h30, 32'h0BAD_F00D);
        do_cmd(0, 32'h30, 32'h0);
        wait_drain();
    endtask

    task automatic test_slverr();
        bresp_cfg = SLVERR;
        do_cmd(1, 32'h80, 32'hCAFE_F00D);
        wait_drain();
        bresp_cfg = OKAY;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        ar_dly = 30;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
        @(posedge clk); #1 cmd_valid = 0;
        @(negedge clk);
        checks++;
        if (axi_arvalid_o !== 1'b1) begin errors++; $display("FAIL mid_arvalid: got %0b required 1", axi_arvalid_o); end
        @(posedge clk); #1 rst_n = 0;
        #1;
        checks += 2;
        if ({axi_arvalid_o, axi_awvalid_o, axi_wvalid_o, rsp_valid_o, axi_rready_o} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_valids: got %b required 00000", {axi_arvalid_o, axi_awvalid_o, axi_wvalid_o, rsp_valid_o, axi_rready_o});
        end
        if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %0b required 1", cmd_ready_o); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        ar_dly = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid_o || axi_arvalid_o) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_reset_quiet: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) do_cmd(1, 32'(i * 4), 32'(i * 4) ^ 32'hA5A5_A5A5);
        for (int i = 0; i < 16; i++) do_cmd(0, 32'(i * 4), 32'h0);
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = '0; exp_mem[i] = '0; end
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_rsp_hold();
        test_slverr();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
